truth_table_sweeper: RTL and testbench

Sequential stimulus and capture stage that sits directly upstream of a 3-input combinational logic module such as m0x95. It drives that module's in1/in2/in3 through all eight input combinations and holds each combination for a programmable settle time. It samples the module's `out` at the end of each hold and assembles the observed 8-bit truth table. It then compares the table against an expected hex code and reports pass/fail and a per-row mismatch mask.

---
 rtl/truth_table_sweeper_if.sv | 23 ++
 rtl/truth_table_sweeper.sv | 84 ++++++++
 tb/tb_truth_table_sweeper.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: stimulus, capture and result signals between the sweeper and its environment
interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic       dut_out;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       busy;
  logic       done;
  logic       results_valid;
  logic [7:0] tbl;
  logic       pass;
  logic [7:0] mismatch_mask;
  modport master (
    input  start, abort, dut_out,
    output in1, in2, in3, busy, done, results_valid, tbl, pass, mismatch_mask
  );
  modport slave (
    output start, abort, dut_out,
    input  in1, in2, in3, busy, done, results_valid, tbl, pass, mismatch_mask
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks a 3-input logic block through all rows, captures and grades its truth table
module truth_table_sweeper #(
  parameter int         SETTLE_CYCLES = 16,
  parameter int         CNT_W         = 8,
  parameter logic [7:0] EXPECTED      = 8'h95
) (
  input logic                   clk,
  input logic                   reset,
  truth_table_sweeper_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  state_t           r_state;
  logic [2:0]       r_row;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_tbl;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  assign {bus.in1, bus.in2, bus.in3} = r_row;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.results_valid = r_valid;
  assign bus.tbl           = r_tbl;
  assign bus.pass          = r_valid && (r_tbl == EXPECTED);
  assign bus.mismatch_mask = r_valid ? (r_tbl ^ EXPECTED) : 8'h00;
  // Sweep FSM: hold each row for SETTLE_CYCLES, sample at the end of the hold; abort beats a final sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_row   <= 3'd0;
      r_cnt   <= '0;
      r_tbl   <= 8'h00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start && !bus.abort) begin
            r_state <= SETTLE;
            r_row   <= 3'd0;
            r_cnt   <= RELOAD;
            r_tbl   <= 8'h00;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (bus.abort) begin
            r_state <= IDLE;
            r_row   <= 3'd0;
            r_busy  <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_tbl[~r_row] <= bus.dut_out;
            if (r_row != 3'd7) begin
              r_row <= r_row + 3'd1;
              r_cnt <= RELOAD;
            end else begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_row   <= 3'd0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_row   <= 3'd0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed checks of sweep timing, capture, grading, abort and reset
module tb_truth_table_sweeper;
  localparam logic [7:0] M = 8'h95;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic inv = 1'b0;
  logic sel = 1'b0;
  int total = 0;
  int bad = 0;
  logic [2:0] o_in [0:63];
  logic       o_busy [0:63];
  logic       o_done [0:63];
  logic [7:0] o_tbl [0:63];
  logic       o_pass [0:63];
  truth_table_sweeper_if b4 ();
  truth_table_sweeper_if b1 ();
  truth_table_sweeper #(.SETTLE_CYCLES(4), .CNT_W(8), .EXPECTED(8'h95)) u4 (.clk(clk), .reset(reset), .bus(b4.master));
  truth_table_sweeper #(.SETTLE_CYCLES(1), .CNT_W(8), .EXPECTED(8'h95)) u1 (.clk(clk), .reset(reset), .bus(b1.master));
  wire [2:0] w_r4 = {b4.in1, b4.in2, b4.in3};
  wire [2:0] w_r1 = {b1.in1, b1.in2, b1.in3};
  assign b4.start   = start;
  assign b4.abort   = abort;
  assign b4.dut_out = M[~w_r4] ^ (inv && w_r4 == 3'd3);
  assign b1.start   = start;
  assign b1.abort   = abort;
  assign b1.dut_out = M[~w_r1] ^ (inv && w_r1 == 3'd3);
  wire [2:0] w_in    = sel ? w_r1 : w_r4;
  wire       w_busy  = sel ? b1.busy : b4.busy;
  wire       w_done  = sel ? b1.done : b4.done;
  wire       w_valid = sel ? b1.results_valid : b4.results_valid;
  wire [7:0] w_tbl   = sel ? b1.tbl : b4.tbl;
  wire       w_pass  = sel ? b1.pass : b4.pass;
  wire [7:0] w_mask  = sel ? b1.mismatch_mask : b4.mismatch_mask;
  always #5 clk = ~clk;
  function automatic logic [2:0] exp_row(input int k, input int s);
    return (k < 8 * s) ? 3'(k / s) : (k == 8 * s) ? 3'd7 : 3'd0;
  endfunction
  task automatic kick;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic observe(input int n, input int ra, input int rb, input int ak);
    for (int k = 0; k < n; k++) begin
      o_in[k] = w_in;
      o_busy[k] = w_busy;
      o_done[k] = w_done;
      o_tbl[k] = w_tbl;
      o_pass[k] = w_pass;
      start = (k == ra - 1) || (k == rb - 1);
      abort = (k == ak - 1);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({w_in, w_busy, w_done, w_valid, w_pass} !== 7'd0) begin
      bad++;
      $display("FAIL reset_ctrl got in=%0d busy=%0b done=%0b valid=%0b pass=%0b want all 0", w_in, w_busy, w_done, w_valid, w_pass);
    end
    total++;
    if (w_tbl !== 8'h00 || w_mask !== 8'h00) begin
      bad++;
      $display("FAIL reset_data got tbl=%h mask=%h want 00 00", w_tbl, w_mask);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_correct;
    int e = 0;
    sel = 1'b0;
    kick();
    observe(34, -1, -1, -1);
    for (int k = 0; k < 34; k++)
      if (o_in[k] !== exp_row(k, 4) || o_busy[k] !== (k < 32) || o_done[k] !== (k == 32)) e++;
    total++;
    if (e != 0) begin
      bad++;
      $display("FAIL correct_timing got %0d bad cycles want 0", e);
    end
    total++;
    if (o_tbl[32] !== 8'h95 || o_pass[32] !== 1'b1) begin
      bad++;
      $display("FAIL correct_at_done got tbl=%h pass=%0b want 95 1", o_tbl[32], o_pass[32]);
    end
    total++;
    if (w_valid !== 1'b1 || w_mask !== 8'h00 || w_pass !== 1'b1) begin
      bad++;
      $display("FAIL correct_result got valid=%0b mask=%h pass=%0b want 1 00 1", w_valid, w_mask, w_pass);
    end
  endtask
  task automatic test_inverted;
    sel = 1'b0;
    inv = 1'b1;
    kick();
    observe(34, -1, -1, -1);
    inv = 1'b0;
    total++;
    if (w_tbl !== 8'h85 || w_mask !== 8'h10) begin
      bad++;
      $display("FAIL inverted_table got tbl=%h mask=%h want 85 10", w_tbl, w_mask);
    end
    total++;
    if (w_pass !== 1'b0 || w_valid !== 1'b1) begin
      bad++;
      $display("FAIL inverted_flags got pass=%0b valid=%0b want 0 1", w_pass, w_valid);
    end
  endtask
  task automatic test_abort;
    int d = 0;
    sel = 1'b0;
    kick();
    observe(40, -1, -1, 13);
    for (int k = 0; k < 40; k++) if (o_done[k] !== 1'b0) d++;
    total++;
    if (o_busy[12] !== 1'b1 || o_busy[13] !== 1'b0 || o_in[13] !== 3'd0) begin
      bad++;
      $display("FAIL abort_stop got busy12=%0b busy13=%0b in13=%0d want 1 0 0", o_busy[12], o_busy[13], o_in[13]);
    end
    total++;
    if (d != 0 || w_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_nodone got dones=%0d valid=%0b want 0 0", d, w_valid);
    end
    total++;
    if (w_tbl !== 8'h80 || w_mask !== 8'h00) begin
      bad++;
      $display("FAIL abort_partial got tbl=%h mask=%h want 80 00", w_tbl, w_mask);
    end
  endtask
  task automatic test_restart;
    int e = 0;
    sel = 1'b0;
    kick();
    observe(34, 5, 20, -1);
    for (int k = 0; k < 34; k++)
      if (o_in[k] !== exp_row(k, 4) || o_busy[k] !== (k < 32) || o_done[k] !== (k == 32)) e++;
    total++;
    if (e != 0) begin
      bad++;
      $display("FAIL restart_timing got %0d bad cycles want 0", e);
    end
    total++;
    if (w_tbl !== 8'h95 || w_pass !== 1'b1) begin
      bad++;
      $display("FAIL restart_result got tbl=%h pass=%0b want 95 1", w_tbl, w_pass);
    end
  endtask
  task automatic test_s1;
    int e = 0;
    sel = 1'b1;
    kick();
    observe(10, -1, -1, -1);
    for (int k = 0; k < 10; k++)
      if (o_in[k] !== exp_row(k, 1) || o_busy[k] !== (k < 8) || o_done[k] !== (k == 8)) e++;
    total++;
    if (e != 0) begin
      bad++;
      $display("FAIL s1_timing got %0d bad cycles want 0", e);
    end
    total++;
    if (w_tbl !== 8'h95 || w_valid !== 1'b1 || w_pass !== 1'b1) begin
      bad++;
      $display("FAIL s1_result got tbl=%h valid=%0b pass=%0b want 95 1 1", w_tbl, w_valid, w_pass);
    end
    sel = 1'b0;
    repeat (30) @(negedge clk);
  endtask
  task automatic test_async_reset;
    int e = 0;
    sel = 1'b0;
    kick();
    repeat (10) @(negedge clk);
    total++;
    if (w_busy !== 1'b1 || w_tbl !== 8'h80) begin
      bad++;
      $display("FAIL areset_pre got busy=%0b tbl=%h want 1 80", w_busy, w_tbl);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({w_in, w_busy, w_done, w_valid, w_pass} !== 7'd0 || w_tbl !== 8'h00 || w_mask !== 8'h00) begin
      bad++;
      $display("FAIL areset_now got in=%0d busy=%0b tbl=%h mask=%h want 0 0 00 00", w_in, w_busy, w_tbl, w_mask);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (w_busy !== 1'b0 || w_in !== 3'd0) begin
      bad++;
      $display("FAIL areset_noresume got busy=%0b in=%0d want 0 0", w_busy, w_in);
    end
    kick();
    observe(34, -1, -1, -1);
    for (int k = 0; k < 34; k++)
      if (o_in[k] !== exp_row(k, 4) || o_busy[k] !== (k < 32) || o_done[k] !== (k == 32)) e++;
    total++;
    if (e != 0 || w_tbl !== 8'h95 || w_pass !== 1'b1) begin
      bad++;
      $display("FAIL areset_sweep got errs=%0d tbl=%h pass=%0b want 0 95 1", e, w_tbl, w_pass);
    end
  endtask
  initial begin
    test_reset();
    test_correct();
    test_inverted();
    test_abort();
    test_restart();
    test_s1();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
